// File: rtl/instr_pack.sv
// Shared definitions for the Hamming encoder: FSM state encoding, default
// memory layout constants and the byte-address helper.
package instr_pack;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        WR_HI = 3'd3,
        WR_LO = 3'd4,
        FIN   = 3'd5
    } state_e;

    localparam int DEF_SRC_BASE = 0;
    localparam int DEF_DST_BASE = 30;
    localparam int DEF_NWORDS   = 15;

    // Byte address of the hi (hi=1) or lo (hi=0) byte of word k; wraps mod 256.
    function automatic logic [7:0] word_addr(input int base, input logic [7:0] k, input logic hi);
        return 8'(base) + 8'({k, 1'b0}) + {7'd0, hi};
    endfunction

endpackage

// File: rtl/hamm_enc11.sv
// Combinational Hamming(15,11) encoder; codeword bit n holds Hamming position n.
// Define HAMM_P0_EN to fill bit 0 with overall even parity (SECDED).
module hamm_enc11 (
    input  logic [10:0] data_i,
    output logic [15:0] code_o
);

    logic p8_s;
    logic p4_s;
    logic p2_s;
    logic p1_s;
    logic p0_s;
    logic [15:1] upper_s;

    assign p8_s = ^data_i[10:4];
    assign p4_s = ^{data_i[10], data_i[9], data_i[8], data_i[7], data_i[3], data_i[2], data_i[1]};
    assign p2_s = ^{data_i[10], data_i[9], data_i[6], data_i[5], data_i[3], data_i[2], data_i[0]};
    assign p1_s = ^{data_i[10], data_i[8], data_i[6], data_i[4], data_i[3], data_i[1], data_i[0]};

    assign upper_s = {data_i[10:4], p8_s, data_i[3], data_i[2], data_i[1], p4_s, data_i[0], p2_s, p1_s};

`ifdef HAMM_P0_EN
    assign p0_s = ^upper_s;
`else
    assign p0_s = 1'b0;
`endif

    assign code_o = {upper_s, p0_s};

endmodule

// File: rtl/hamm_encoder.sv
// Memory-to-memory Hamming encoder: reads NWORDS raw 11-bit words from SRC_BASE,
// writes 16-bit codewords to DST_BASE, highest word first. Optional HAMM_P0_EN.
module hamm_encoder
    import instr_pack::*;
#(
    parameter int SRC_BASE = DEF_SRC_BASE,
    parameter int DST_BASE = DEF_DST_BASE,
    parameter int NWORDS   = DEF_NWORDS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic       busy,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic [7:0] mem_wdata,
    output logic       mem_we
);

    state_e      state_q;
    logic [7:0]  k_q;
    logic [2:0]  hi_q;
    logic [7:0]  lo_q;
    logic        done_q;
    logic        busy_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic [10:0] enc_in_s;
    logic [15:0] code_s;

    // Encoder input: in RD_LO the lo byte is still on the bus, afterwards it is registered.
    always_comb begin
        enc_in_s = {hi_q, lo_q};
        if (state_q == RD_LO) begin
            enc_in_s = {hi_q, mem_rdata};
        end else begin
            enc_in_s = {hi_q, lo_q};
        end
    end

    hamm_enc11 u_enc (
        .data_i (enc_in_s),
        .code_o (code_s)
    );

    // Control FSM; bus outputs are loaded on entry to the state that presents them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= 8'd0;
            hi_q    <= 3'd0;
            lo_q    <= 8'd0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 8'd0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RD_HI;
                        k_q     <= 8'(NWORDS - 1);
                        busy_q  <= 1'b1;
                        addr_q  <= word_addr(SRC_BASE, 8'(NWORDS - 1), 1'b1);
                    end
                end
                RD_HI: begin
                    hi_q    <= mem_rdata[2:0];
                    addr_q  <= word_addr(SRC_BASE, k_q, 1'b0);
                    state_q <= RD_LO;
                end
                RD_LO: begin
                    lo_q    <= mem_rdata;
                    addr_q  <= word_addr(DST_BASE, k_q, 1'b1);
                    wdata_q <= code_s[15:8];
                    we_q    <= 1'b1;
                    state_q <= WR_HI;
                end
                WR_HI: begin
                    addr_q  <= word_addr(DST_BASE, k_q, 1'b0);
                    wdata_q <= code_s[7:0];
                    state_q <= WR_LO;
                end
                WR_LO: begin
                    we_q    <= 1'b0;
                    wdata_q <= 8'd0;
                    if (k_q != 8'd0) begin
                        k_q     <= k_q - 8'd1;
                        addr_q  <= word_addr(SRC_BASE, k_q - 8'd1, 1'b1);
                        state_q <= RD_HI;
                    end else begin
                        addr_q  <= 8'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    if (!start) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    addr_q  <= 8'd0;
                    wdata_q <= 8'd0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

endmodule

// File: doc/hamm_encoder.md
HAMM_ENCODER -- requirements
Module: hamm_encoder

Interface
REQ-001 SHALL have parameter SRC_BASE, default 0, byte address of first source (raw 11-bit) word.
REQ-002 SHALL have parameter DST_BASE, default 30, byte address of first destination (encoded 16-bit) word.
REQ-003 SHALL have parameter NWORDS, default 15, number of words encoded per run.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port start  input  1  level-sampled request to begin a run.
REQ-007 SHALL have port done  output  1  run complete.
REQ-008 SHALL have port busy  output  1  run in progress.
REQ-009 SHALL have port mem_addr  output  8  data-memory byte address.
REQ-010 SHALL have port mem_rdata  input  8  combinational read data for mem_addr.
REQ-011 SHALL have port mem_wdata  output  8  write data.
REQ-012 SHALL have port mem_we  output  1  write enable; memory writes mem_wdata at mem_addr on the clk edge.

Function
REQ-013 SHALL implement FSM states IDLE, RD_HI, RD_LO, WR_HI, WR_LO, FIN.
REQ-014 SHALL leave IDLE for RD_HI on the first edge with start=1, loading word index k=NWORDS-1.
REQ-015 Word k SHALL occupy src hi byte at SRC_BASE+2k+1 (bits [2:0]={b11,b10,b9}, bits [7:3] ignored) and lo byte at SRC_BASE+2k ({b8..b1}).
REQ-016 RD_HI SHALL drive the src hi address and register mem_rdata[2:0]; RD_LO SHALL drive the src lo address and register mem_rdata.
REQ-017 WR_HI SHALL write {b11,b10,b9,b8,b7,b6,b5,p8} to DST_BASE+2k+1 with mem_we=1.
REQ-018 WR_LO SHALL write {b4,b3,b2,p4,b1,p2,p1,p0} to DST_BASE+2k with mem_we=1.
REQ-019 Parity SHALL be even: p8=^{b11..b5}; p4=^{b11,b10,b9,b8,b4,b3,b2}; p2=^{b11,b10,b7,b6,b4,b3,b1}; p1=^{b11,b9,b7,b5,b4,b2,b1}.
REQ-020 From WR_LO, k>0 SHALL decrement k and go to RD_HI; k=0 SHALL go to FIN.
REQ-021 Each word SHALL take exactly 4 cycles; done SHALL rise 4*NWORDS cycles after the start-accepting edge.
REQ-022 busy SHALL be 1 in RD_HI..WR_LO; done SHALL be 1 only in FIN.
REQ-023 FIN SHALL hold until start=0, then return to IDLE; start held high SHALL NOT retrigger.
REQ-024 start asserted while busy SHALL be ignored.
REQ-025 mem_we SHALL be 0 outside WR_HI/WR_LO; mem_addr and mem_wdata SHALL be 0 in IDLE and FIN.
REQ-026 Address arithmetic SHALL be 8-bit unsigned and wrap modulo 256.

Reset
REQ-027 reset SHALL asynchronously force IDLE, k=0, data registers=0, and done=busy=mem_we=mem_addr=mem_wdata=0.
REQ-028 reset mid-run SHALL abort immediately with no further writes; bytes already written SHALL remain.

Configuration
REQ-029 With HAMM_P0_EN defined, p0 SHALL be the even parity of all 15 other encoded bits (SECDED).
REQ-030 Without HAMM_P0_EN, p0 SHALL be 0 (plain Hamming(15,11)); all other behaviour SHALL be unchanged.

Structure
REQ-031 The FSM state enum and the default SRC_BASE/DST_BASE/NWORDS constants SHALL live in instr_pack.
REQ-032 Parity generation SHALL be a combinational sub-module hamm_enc11 (11-bit in, 16-bit out), instantiated once.

Verification
REQ-033 Raw 11'h000 -> hi 8'h00, lo 8'h00.
REQ-034 Raw 11'h7FF -> hi 8'hFF, lo 8'hFF (HAMM_P0_EN); lo 8'hFE without it.
REQ-035 Raw 11'h001 -> hi 8'h00, lo 8'h0F (HAMM_P0_EN); lo 8'h0E without it.
REQ-036 Raw 11'h400 -> hi 8'h81, lo 8'h17 (HAMM_P0_EN); lo 8'h16 without it.
REQ-037 Full 15-word run with start held high -> done exactly 60 cycles after acceptance, held until start=0, no retrigger, dst bytes 30..59 written once each.
REQ-038 reset pulsed during word 7 -> all outputs 0 immediately, no further mem_we, words 14..8 intact in memory.
